// File: rtl/fp16_divider_iter.sv
// fp16_divider_iter
//   Iterative IEEE-754 binary16 divider, out = a / b, round-to-nearest-even.
//   It holds one operation at a time. A restoring divider produces one quotient
//   bit per cycle. Specials use the multiplier's encodings: the canonical NaN is
//   16'h7e00, infinity is {s,15'h7c00} and zero is {s,15'h0}.
//   Latency from the accept edge to out_valid is 2 cycles for specials and
//   17 cycles otherwise.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous reset, active-high
//   in_valid   in   1   a/b valid
//   in_ready   out  1   high only while idle
//   a, b       in   16  dividend / divisor (fp16)
//   out_valid  out  1   result valid, held until out_ready
//   out_ready  in   1   consumer accepts result
//   out        out  16  quotient (fp16)
//   flags      out  5   {invalid,divzero,overflow,underflow,inexact}
//                       present only when FP16_DIV_FLAGS_EN is defined
//
// Configuration macro: FP16_DIV_FLAGS_EN (adds the registered flags port).
module fp16_divider_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out
`ifdef FP16_DIV_FLAGS_EN
  ,
  output logic [4:0]  flags
`endif
);

  // Quotient bits: 11 mantissa + guard + round + 1 normalisation bit.
  // The rounding bit positions below assume this width.
  localparam int          QBITS = 14;
  localparam logic [15:0] QNAN  = 16'h7e00;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIVIDE, S_ROUND, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [15:0]       r_a, r_b, r_out;
  logic              r_sign;
  logic signed [7:0] r_exp;
  logic [11:0]       r_rem;
  logic [10:0]       r_mb;
  logic [13:0]       r_q;
  logic [3:0]        r_cnt;
`ifdef FP16_DIV_FLAGS_EN
  logic [4:0]        r_flags, w_spc_flags, w_rnd_flags;
`endif

  // Leading-zero count of an 11-bit significand. A zero input never reaches
  // this path.
  function automatic logic [3:0] lead_zeros(input logic [10:0] m);
    logic [3:0] n;
    logic       found;
    n     = 4'd0;
    found = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      n = n + 4'd1;
      end
    end
    return n;
  endfunction

  // ---------------- operand decode (valid in PREP) ----------------
  logic              w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan, w_sign;
  logic [10:0]       w_ma_raw, w_mb_raw, w_ma, w_mb;
  logic [3:0]        w_lza, w_lzb;
  logic [7:0]        w_ea_base, w_eb_base;
  logic signed [7:0] w_ea, w_eb, w_e;

  assign w_sign   = r_a[15] ^ r_b[15];
  assign w_a_zero = (r_a[14:0] == 15'd0);
  assign w_b_zero = (r_b[14:0] == 15'd0);
  assign w_a_inf  = (r_a[14:10] == 5'h1f) && (r_a[9:0] == 10'd0);
  assign w_b_inf  = (r_b[14:10] == 5'h1f) && (r_b[9:0] == 10'd0);
  assign w_a_nan  = (r_a[14:10] == 5'h1f) && (r_a[9:0] != 10'd0);
  assign w_b_nan  = (r_b[14:10] == 5'h1f) && (r_b[9:0] != 10'd0);

  // Subnormals are normalised to bit10=1 and get exponent 1-lz.
  assign w_ma_raw  = {r_a[14:10] != 5'd0, r_a[9:0]};
  assign w_mb_raw  = {r_b[14:10] != 5'd0, r_b[9:0]};
  assign w_lza     = lead_zeros(w_ma_raw);
  assign w_lzb     = lead_zeros(w_mb_raw);
  assign w_ma      = w_ma_raw << w_lza;
  assign w_mb      = w_mb_raw << w_lzb;
  assign w_ea_base = (r_a[14:10] == 5'd0) ? 8'd1 : {3'b000, r_a[14:10]};
  assign w_eb_base = (r_b[14:10] == 5'd0) ? 8'd1 : {3'b000, r_b[14:10]};
  assign w_ea      = w_ea_base - {4'b0000, w_lza};
  assign w_eb      = w_eb_base - {4'b0000, w_lzb};
  assign w_e       = w_ea - w_eb + 8'sd15;

  logic        w_special;
  logic [15:0] w_spc_out;

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_special = 1'b1;
    w_spc_out = QNAN;
`ifdef FP16_DIV_FLAGS_EN
    w_spc_flags = 5'b00000;
`endif
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spc_out = QNAN;
`ifdef FP16_DIV_FLAGS_EN
      w_spc_flags = 5'b10000;
`endif
    end else if (w_a_inf || w_b_zero) begin
      w_spc_out = {w_sign, 15'h7c00};
`ifdef FP16_DIV_FLAGS_EN
      if (!w_a_inf) w_spc_flags = 5'b01000;
`endif
    end else if (w_a_zero || w_b_inf) begin
      w_spc_out = {w_sign, 15'h0000};
    end else begin
      w_special = 1'b0;
    end
  end

  // ---------------- restoring divide step ----------------
  logic        w_ge;
  logic [11:0] w_rem_sub;
  assign w_ge      = (r_rem >= {1'b0, r_mb});
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  // ---------------- normalise, denormalise, round ----------------
  logic [15:0] w_rnd_out;
  always_comb begin
    logic [13:0]       q_n, q_s, lost_mask;
    logic signed [7:0] e_n;
    logic [7:0]        sh;
    logic [4:0]        sh_c;
    logic              g, rb, st, up, ovf, tiny;
    logic [14:0]       mag;
    q_n  = r_q[13] ? r_q : {r_q[12:0], 1'b0};
    e_n  = r_q[13] ? r_exp : (r_exp - 8'sd1);
    tiny = (e_n <= 8'sd0);
    sh   = 8'sd1 - e_n;
    // Results below the normal range are shifted right by 1-e before rounding.
    // This rounds only once. Shifts of 15 or more leave nothing but sticky.
    if (!tiny)             sh_c = 5'd0;
    else if (sh < 8'd15)   sh_c = sh[4:0];
    else                   sh_c = 5'd15;
    q_s       = q_n >> sh_c;
    lost_mask = ~(14'h3fff << sh_c);
    g   = q_s[2];
    rb  = q_s[1];
    st  = q_s[0] | (|(q_n & lost_mask)) | (r_rem != 12'd0);
    up  = g & (rb | st | q_s[3]);
    // A mantissa carry ripples into the exponent field. A subnormal that rounds
    // up to 0x400 therefore becomes the minimum normal (exp=1).
    if (tiny) mag = {5'd0, q_s[12:3]} + {14'd0, up};
    else      mag = {e_n[4:0], q_s[12:3]} + {14'd0, up};
    ovf = !tiny && ((e_n >= 8'sd31) || (mag[14:10] == 5'h1f));
    w_rnd_out = ovf ? {r_sign, 15'h7c00} : {r_sign, mag};
`ifdef FP16_DIV_FLAGS_EN
    w_rnd_flags = {2'b00, ovf, tiny & (g | rb | st), g | rb | st | ovf};
`endif
  end

  // ---------------- control FSM ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_next = S_PREP;
      S_PREP:   w_next = w_special ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (r_cnt == 4'(QBITS - 1)) w_next = S_ROUND;
      S_ROUND:  w_next = S_DONE;
      S_DONE:   if (out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments. Every register
  // then samples values from before the edge, whatever the block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= 16'd0;
      r_b    <= 16'd0;
      r_out  <= 16'd0;
      r_sign <= 1'b0;
      r_exp  <= 8'sd0;
      r_rem  <= 12'd0;
      r_mb   <= 11'd0;
      r_q    <= 14'd0;
      r_cnt  <= 4'd0;
`ifdef FP16_DIV_FLAGS_EN
      r_flags <= 5'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a <= a;
          r_b <= b;
`ifdef FP16_DIV_FLAGS_EN
          r_flags <= 5'd0;
`endif
        end
        S_PREP: begin
          if (w_special) begin
            r_out <= w_spc_out;
`ifdef FP16_DIV_FLAGS_EN
            r_flags <= w_spc_flags;
`endif
          end else begin
            r_sign <= w_sign;
            r_exp  <= w_e;
            r_rem  <= {1'b0, w_ma};
            r_mb   <= w_mb;
            r_q    <= 14'd0;
            r_cnt  <= 4'd0;
          end
        end
        S_DIVIDE: begin
          r_rem <= w_rem_sub << 1;
          r_q   <= {r_q[12:0], w_ge};
          r_cnt <= r_cnt + 4'd1;
        end
        S_ROUND: begin
          r_out <= w_rnd_out;
`ifdef FP16_DIV_FLAGS_EN
          r_flags <= w_rnd_flags;
`endif
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out       = r_out;
`ifdef FP16_DIV_FLAGS_EN
  assign flags     = r_flags;
`endif

endmodule

// File: tb/tb_fp16_divider_iter.sv
// Self-checking bench for fp16_divider_iter: directed vector table, randomized
// operands against a rational-arithmetic reference model, backpressure and
// mid-operation reset sequences.
module tb_fp16_divider_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out;
`ifdef FP16_DIV_FLAGS_EN
  logic [4:0]  flags;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp16_divider_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef FP16_DIV_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_special(input logic [15:0] x, input logic [15:0] y);
    return (x[14:10] == 5'h1f) || (y[14:10] == 5'h1f) || (x[14:0] == 15'd0) || (y[14:0] == 15'd0);
  endfunction

  // Reference: the exact quotient ma/mb * 2^(ea-eb) is rounded onto the fp16
  // grid. The exponent is found by searching for the integer significand M.
  function automatic void ref_div(input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] r, output logic [4:0] f);
    logic   s;
    bit     xn, yn, xi, yi, xz, yz, inexact, up;
    int     ex, ey, k, e, sft;
    longint mx, my, num, den, m, rem, bits;
    s  = x[15] ^ y[15];
    xn = (x[14:10] == 5'h1f) && (x[9:0] != 0);
    yn = (y[14:10] == 5'h1f) && (y[9:0] != 0);
    xi = (x[14:10] == 5'h1f) && (x[9:0] == 0);
    yi = (y[14:10] == 5'h1f) && (y[9:0] == 0);
    xz = (x[14:0] == 0);
    yz = (y[14:0] == 0);
    f  = 5'b00000;
    if (xn || yn || (xz && yz) || (xi && yi)) begin r = 16'h7e00; f = 5'b10000; return; end
    if (xi) begin r = {s, 15'h7c00}; return; end
    if (yz) begin r = {s, 15'h7c00}; f = 5'b01000; return; end
    if (xz || yi) begin r = {s, 15'h0000}; return; end
    ex = (x[14:10] == 0) ? 1 : int'(x[14:10]);
    ey = (y[14:10] == 0) ? 1 : int'(y[14:10]);
    mx = (x[14:10] == 0) ? longint'(x[9:0]) : 1024 + longint'(x[9:0]);
    my = (y[14:10] == 0) ? longint'(y[9:0]) : 1024 + longint'(y[9:0]);
    k  = ex - ey;
    e  = 31;
    do begin
      e--;
      sft = k + 25 - e;
      if (sft >= 0) begin num = mx << sft; den = my; end
      else begin num = mx; den = my << (-sft); end
      m = num / den;
    end while (m < 1024 && e > 1);
    rem     = num - m * den;
    inexact = (rem != 0);
    up      = (2 * rem > den) || ((2 * rem == den) && (m % 2 == 1));
    bits    = longint'(e - 1) * 1024 + m + longint'(up);
    if (bits >= 31744) begin
      r = {s, 15'h7c00};
      f = 5'b00101;
    end else begin
      r = {s, bits[14:0]};
      f = {3'b000, (m < 1024) && inexact, inexact};
    end
  endfunction

  // Called at posedge+#1 with the bench idle. lat counts the accept edge as 1.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_,
                        output logic [15:0] res, output int lat, output logic [4:0] fl);
    int w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    a = ta; b = tb_; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    res = out;
`ifdef FP16_DIV_FLAGS_EN
    fl = flags;
`else
    fl = 5'b00000;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          lat;
    logic [4:0]  fl;
  } vec_t;

  initial begin
    vec_t        vecs[10];
    logic [15:0] res, ra, rb, er;
    logic [4:0]  fl, ef;
    int          lat, w;

    vecs[0] = '{16'h4200, 16'h4000, 16'h3e00, 17, 5'b00000};
    vecs[1] = '{16'h3c00, 16'h4200, 16'h3555, 17, 5'b00001};
    vecs[2] = '{16'hbc00, 16'h4200, 16'hb555, 17, 5'b00001};
    vecs[3] = '{16'h3c00, 16'h0000, 16'h7c00,  2, 5'b01000};
    vecs[4] = '{16'h0000, 16'h0000, 16'h7e00,  2, 5'b10000};
    vecs[5] = '{16'h7c00, 16'h7c00, 16'h7e00,  2, 5'b10000};
    vecs[6] = '{16'h0000, 16'h4000, 16'h0000,  2, 5'b00000};
    vecs[7] = '{16'h7bff, 16'h3800, 16'h7c00, 17, 5'b00101};
    vecs[8] = '{16'h0400, 16'h4000, 16'h0200, 17, 5'b00000};
    vecs[9] = '{16'h0001, 16'h4000, 16'h0000, 17, 5'b00011};

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out", out, 16'h0000);
`ifdef FP16_DIV_FLAGS_EN
    check("reset_flags", flags, 5'b00000);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, res, lat, fl);
      check($sformatf("vec%0d_out", i), res, vecs[i].res);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
`ifdef FP16_DIV_FLAGS_EN
      check($sformatf("vec%0d_flags", i), fl, vecs[i].fl);
`endif
    end

    // Randomized operands, biased towards subnormal/tiny and huge ranges
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 3))
        0: ra[14:10] = 5'(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4));
        1: rb[14:10] = 5'($urandom_range(26, 30));
        default: ;
      endcase
      ref_div(ra, rb, er, ef);
      run_op(ra, rb, res, lat, fl);
      check($sformatf("rand%0d_out a=%h b=%h", i, ra, rb), res, er);
      check($sformatf("rand%0d_lat", i), lat, is_special(ra, rb) ? 2 : 17);
`ifdef FP16_DIV_FLAGS_EN
      check($sformatf("rand%0d_flags a=%h b=%h", i, ra, rb), fl, ef);
`endif
    end

    // Backpressure: result held, busy ignores new requests
    a = 16'h4200; b = 16'h4000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
    check("bp_out_valid", out_valid, 1);
    check("bp_out", out, 16'h3e00);
    a = 16'h4400; b = 16'h4000; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_out_%0d", i), out, 16'h3e00);
      check($sformatf("bp_hold_valid_%0d", i), out_valid, 1);
      check($sformatf("bp_hold_in_ready_%0d", i), in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_after_out_valid", out_valid, 0);
    check("bp_after_in_ready", in_ready, 1);

    // Reset asserted in the middle of DIVIDE
    a = 16'h4200; b = 16'h4000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out", out, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(16'h4400, 16'h4000, res, lat, fl);
    check("post_rst_out", res, 16'h4000);
    check("post_rst_lat", lat, 17);
`ifdef FP16_DIV_FLAGS_EN
    check("post_rst_flags", fl, 5'b00000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
